// File: rtl/gb_cpu_common_pkg.sv
// Shared CPU types: per-M-cycle control word, instruction schedules, condition codes,
// plus the opcode-fetch control word / schedule and the branch condition helper.
package gb_cpu_common_pkg;

  localparam int MAX_MCYCLES = 6;

  typedef enum logic [2:0] {
    REG16_NONE = 3'd0, REG16_PC, REG16_SP, REG16_HL, REG16_BC, REG16_DE, REG16_WZ
  } reg16_t;

  typedef enum logic [3:0] {
    REG_NONE = 4'd0, REG_IR, REG_A, REG_F, REG_B, REG_C, REG_D, REG_E,
    REG_H, REG_L, REG_W, REG_Z
  } reg8_t;

  typedef enum logic [1:0] {IDU_NOP = 2'd0, IDU_INC, IDU_DEC} idu_op_t;

  typedef enum logic [3:0] {
    ALU_NOP = 4'd0, ALU_ADD, ALU_ADC, ALU_SUB, ALU_SBC, ALU_AND, ALU_XOR, ALU_OR, ALU_CP
  } alu_op_t;

  typedef enum logic [1:0] {CC_NZ = 2'd0, CC_Z, CC_NC, CC_C} condition_code_t;

  typedef struct packed {
    reg16_t  addr_src;
    logic    receive_data_bus;
    reg8_t   data_dst;
    logic    write_data_bus;
    reg8_t   data_src;
    idu_op_t idu_op;
    reg16_t  idu_src;
    reg16_t  idu_dst;
    logic    idu_wren;
    alu_op_t alu_op;
    logic    cc_check;
  } control_signals_t;

  typedef struct packed {
    logic [2:0]                              m_cycles;
    condition_code_t                         condition;
    logic                                    cb_prefix_next;
    logic                                    bit_cmd;
    control_signals_t [MAX_MCYCLES-1:0]      instruction_controls;
  } schedule_t;

  localparam control_signals_t FETCH_CTRL = '{
    addr_src: REG16_PC, receive_data_bus: 1'b1, data_dst: REG_IR,
    write_data_bus: 1'b0, data_src: REG_NONE,
    idu_op: IDU_INC, idu_src: REG16_PC, idu_dst: REG16_PC, idu_wren: 1'b1,
    alu_op: ALU_NOP, cc_check: 1'b0
  };

  localparam schedule_t FETCH_SCHEDULE = '{
    m_cycles: 3'd1, condition: CC_NZ, cb_prefix_next: 1'b0, bit_cmd: 1'b0,
    instruction_controls: {{((MAX_MCYCLES-1)*$bits(control_signals_t)){1'b0}}, FETCH_CTRL}
  };

  function automatic logic cond_check(condition_code_t cc, logic z, logic c);
    logic res;
    unique case (cc)
      CC_NZ:   res = ~z;
      CC_Z:    res = z;
      CC_NC:   res = ~c;
      default: res = c;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/gb_cpu_sequencer_if.sv
// Decoder <-> sequencer link: the schedule the decoder offers and the table/IRQ
// selects the sequencer hands back.
interface gb_cpu_sequencer_if;
  import gb_cpu_common_pkg::*;

  schedule_t schedule;
  logic      cb_mode;
  logic      irq_select;
  logic      bit_cmd;

  modport master (output schedule, input cb_mode, irq_select, bit_cmd);
  modport slave  (input schedule, output cb_mode, irq_select, bit_cmd);
endinterface

// File: rtl/gb_cpu_sequencer.sv
// M-cycle sequencer: steps through the running instruction's schedule, handles
// conditional early exit, CB prefixing and interrupt dispatch insertion.
module gb_cpu_sequencer
  import gb_cpu_common_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mcycle_en,
  input  schedule_t        schedule_i,
  input  logic             flag_z,
  input  logic             flag_c,
  input  logic             irq_take,
  output control_signals_t ctrl_o,
  output logic [2:0]       cycle_idx_o,
  output logic             cb_mode_o,
  output logic             bit_cmd_o,
  output logic             irq_select_o,
  output logic             irq_active_o,
  output logic             boundary_o
);

  schedule_t  sched_q, sched_d;
  logic [2:0] idx_q, idx_d;
  logic       cb_q, cb_d;
  logic       irq_q, irq_d;

  logic [2:0] last_idx;
  logic       at_last;
  logic       cc_fail;

  // m_cycles of 0 runs as a single-cycle instruction; >6 saturates at entry 5
  always_comb begin
    if (sched_q.m_cycles == 3'd0)      last_idx = 3'd0;
    else if (sched_q.m_cycles >= 3'd6) last_idx = 3'd5;
    else                               last_idx = sched_q.m_cycles - 3'd1;
  end

  assign ctrl_o       = sched_q.instruction_controls[idx_q];
  assign at_last      = (idx_q == last_idx);
  assign cc_fail      = ctrl_o.cc_check & ~cond_check(sched_q.condition, flag_z, flag_c);
  assign boundary_o   = at_last | cc_fail;
  assign irq_select_o = at_last & irq_take & ~sched_q.cb_prefix_next & ~irq_q;
  assign cb_mode_o    = sched_q.cb_prefix_next & at_last;
  assign bit_cmd_o    = sched_q.bit_cmd;
  assign irq_active_o = irq_q;
  assign cycle_idx_o  = idx_q;

  always_comb begin
    sched_d = sched_q;
    idx_d   = idx_q;
    cb_d    = cb_q;
    irq_d   = irq_q;
    if (mcycle_en) begin
      // a failed condition on the final entry is irrelevant: reload wins
      if (at_last) begin
        sched_d = schedule_i;
        idx_d   = 3'd0;
        cb_d    = sched_q.cb_prefix_next;
        irq_d   = irq_select_o;
      end else if (cc_fail) begin
        idx_d = last_idx;
      end else begin
        idx_d = idx_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sched_q <= FETCH_SCHEDULE;
      idx_q   <= 3'd0;
      cb_q    <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      sched_q <= sched_d;
      idx_q   <= idx_d;
      cb_q    <= cb_d;
      irq_q   <= irq_d;
    end
  end

endmodule

// File: tb/tb_gb_cpu_sequencer.sv
// Self-checking bench for gb_cpu_sequencer: directed scenarios with literal
// expectations, then randomized traffic against a cycle-level behavioural model.
module tb_gb_cpu_sequencer;
  import gb_cpu_common_pkg::*;

  logic clk = 1'b0;
  logic rst_n, mcycle_en, flag_z, flag_c, irq_take;
  control_signals_t ctrl_o;
  logic [2:0] cycle_idx_o;
  logic irq_active_o, boundary_o;

  gb_cpu_sequencer_if dbus ();

  gb_cpu_sequencer dut (
    .clk(clk), .rst_n(rst_n), .mcycle_en(mcycle_en), .schedule_i(dbus.schedule),
    .flag_z(flag_z), .flag_c(flag_c), .irq_take(irq_take),
    .ctrl_o(ctrl_o), .cycle_idx_o(cycle_idx_o), .cb_mode_o(dbus.cb_mode),
    .bit_cmd_o(dbus.bit_cmd), .irq_select_o(dbus.irq_select),
    .irq_active_o(irq_active_o), .boundary_o(boundary_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  schedule_t m_sched;
  int        m_idx;
  bit        m_cb, m_irq, model_valid = 0;

  function automatic int m_last(schedule_t s);
    int m = int'(s.m_cycles);
    if (m == 0) return 0;
    return (m - 1 > 5) ? 5 : m - 1;
  endfunction

  function automatic bit m_cond(logic [1:0] cc, logic z, logic c);
    // 0:NZ 1:Z 2:NC 3:C
    case (cc)
      2'd0: return !z;
      2'd1: return z;
      2'd2: return !c;
      default: return c;
    endcase
  endfunction

  function automatic bit m_ccfail(schedule_t s, int idx, logic z, logic c);
    return s.instruction_controls[idx].cc_check && !m_cond(s.condition, z, c);
  endfunction

  function automatic bit m_irqsel(schedule_t s, int idx, bit irqq, logic take);
    return (idx == m_last(s)) && take && !s.cb_prefix_next && !irqq;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_sched     <= FETCH_SCHEDULE;
      m_idx       <= 0;
      m_cb        <= 0;
      m_irq       <= 0;
      model_valid <= 1;
    end else if (mcycle_en && model_valid) begin
      if (m_idx == m_last(m_sched)) begin
        m_cb    <= m_sched.cb_prefix_next;
        m_irq   <= m_irqsel(m_sched, m_idx, m_irq, irq_take);
        m_sched <= dbus.schedule;
        m_idx   <= 0;
      end else if (m_ccfail(m_sched, m_idx, flag_z, flag_c)) begin
        m_idx <= m_last(m_sched);
      end else begin
        m_idx <= m_idx + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (model_valid && rst_n) begin
      chk("ctrl", 64'(ctrl_o), 64'(m_sched.instruction_controls[m_idx]));
      chk("idx", 64'(cycle_idx_o), 64'(m_idx));
      chk("boundary", 64'(boundary_o),
          64'((m_idx == m_last(m_sched)) || m_ccfail(m_sched, m_idx, flag_z, flag_c)));
      chk("cb_mode", 64'(dbus.cb_mode), 64'(m_sched.cb_prefix_next && m_idx == m_last(m_sched)));
      chk("bit_cmd", 64'(dbus.bit_cmd), 64'(m_sched.bit_cmd));
      chk("irq_select", 64'(dbus.irq_select), 64'(m_irqsel(m_sched, m_idx, m_irq, irq_take)));
      chk("irq_active", 64'(irq_active_o), 64'(m_irq));
      chk("cb_q", 64'(dut.cb_q), 64'(m_cb));
    end
  end

  // ---------------- stimulus ----------------
  schedule_t JR, CBP, CBOP, DISP, SIX, ZERO;

  function automatic control_signals_t rnd_ctrl(bit allow_cc);
    logic [31:0] r = $urandom();
    control_signals_t c = r[$bits(control_signals_t)-1:0];
    if (!allow_cc) c.cc_check = 1'b0;
    return c;
  endfunction

  function automatic schedule_t rnd_sched();
    schedule_t s = '0;
    logic [31:0] r = $urandom();
    s.m_cycles       = r[2:0];
    s.condition      = condition_code_t'(r[4:3]);
    s.cb_prefix_next = (r[7:5] == 3'd0);
    s.bit_cmd        = r[8];
    for (int k = 0; k < 6; k++) s.instruction_controls[k] = rnd_ctrl(1'b1);
    return s;
  endfunction

  task automatic step(input schedule_t s);
    dbus.schedule = s;
    mcycle_en = 1'b1;
    @(posedge clk);
    #1;
    mcycle_en = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 0; mcycle_en = 0; flag_z = 0; flag_c = 0; irq_take = 0;
    dbus.schedule = FETCH_SCHEDULE;

    JR = '0; JR.m_cycles = 3'd3; JR.condition = CC_NZ;
    JR.instruction_controls[0] = rnd_ctrl(1'b0);
    JR.instruction_controls[0].cc_check = 1'b1;
    JR.instruction_controls[1] = rnd_ctrl(1'b0);
    JR.instruction_controls[2] = FETCH_CTRL;
    CBP = FETCH_SCHEDULE; CBP.cb_prefix_next = 1'b1;
    CBOP = '0; CBOP.m_cycles = 3'd2; CBOP.bit_cmd = 1'b1;
    CBOP.instruction_controls[0] = rnd_ctrl(1'b0);
    CBOP.instruction_controls[1] = FETCH_CTRL;
    DISP = '0; DISP.m_cycles = 3'd5;
    SIX = '0; SIX.m_cycles = 3'd6;
    for (int k = 0; k < 6; k++) begin
      DISP.instruction_controls[k] = rnd_ctrl(1'b0);
      SIX.instruction_controls[k]  = rnd_ctrl(1'b0);
    end
    ZERO = '0; ZERO.instruction_controls[0].alu_op = ALU_ADD;

    do_reset();
    chk("rst_ctrl", 64'(ctrl_o), 64'(FETCH_CTRL));
    chk("rst_idx", 64'(cycle_idx_o), 64'd0);
    chk("rst_boundary", 64'(boundary_o), 64'd1);
    chk("rst_cb_mode", 64'(dbus.cb_mode), 64'd0);
    chk("rst_irq_select", 64'(dbus.irq_select), 64'd0);
    chk("rst_irq_active", 64'(irq_active_o), 64'd0);
    chk("rst_bit_cmd", 64'(dbus.bit_cmd), 64'd0);

    for (int i = 0; i < 3; i++) begin
      step(FETCH_SCHEDULE);
      chk("fetch_idx", 64'(cycle_idx_o), 64'd0);
      chk("fetch_ctrl", 64'(ctrl_o), 64'(FETCH_CTRL));
    end

    // JR NZ not taken: 0 -> 2 -> reload
    flag_z = 1'b1;
    step(JR);
    chk("jr_nt_idx0", 64'(cycle_idx_o), 64'd0);
    chk("jr_nt_bnd0", 64'(boundary_o), 64'd1);
    step(FETCH_SCHEDULE);
    chk("jr_nt_idx2", 64'(cycle_idx_o), 64'd2);
    step(FETCH_SCHEDULE);
    chk("jr_nt_reload", 64'(ctrl_o), 64'(FETCH_CTRL));
    // JR NZ taken: 0 -> 1 -> 2
    flag_z = 1'b0;
    step(JR);
    chk("jr_t_bnd0", 64'(boundary_o), 64'd0);
    step(FETCH_SCHEDULE);
    chk("jr_t_idx1", 64'(cycle_idx_o), 64'd1);
    step(FETCH_SCHEDULE);
    chk("jr_t_idx2", 64'(cycle_idx_o), 64'd2);
    step(FETCH_SCHEDULE);
    chk("jr_t_reload", 64'(cycle_idx_o), 64'd0);

    // CB prefix with pending interrupt, then dispatch
    step(CBP);
    irq_take = 1'b1;
    #1;
    chk("cbp_cb_mode", 64'(dbus.cb_mode), 64'd1);
    chk("cbp_irq_blocked", 64'(dbus.irq_select), 64'd0);
    step(CBOP);
    chk("cbop_cb_q", 64'(dut.cb_q), 64'd1);
    chk("cbop_bit_cmd", 64'(dbus.bit_cmd), 64'd1);
    chk("cbop_cb_mode", 64'(dbus.cb_mode), 64'd0);
    step(FETCH_SCHEDULE);
    chk("cbop_irq_select", 64'(dbus.irq_select), 64'd1);
    step(DISP);
    for (int i = 0; i < 5; i++) begin
      chk("disp_active", 64'(irq_active_o), 64'd1);
      chk("disp_idx", 64'(cycle_idx_o), 64'(i));
      chk("disp_no_reselect", 64'(dbus.irq_select), 64'd0);
      if (i == 4) irq_take = 1'b0;
      step(FETCH_SCHEDULE);
    end
    chk("disp_done_active", 64'(irq_active_o), 64'd0);

    // stall mid-instruction, then reset at idx 3
    step(SIX);
    repeat (3) step(FETCH_SCHEDULE);
    chk("stall_idx_pre", 64'(cycle_idx_o), 64'd3);
    for (int i = 0; i < 10; i++) begin
      flag_z = $urandom_range(0, 1); flag_c = $urandom_range(0, 1);
      irq_take = $urandom_range(0, 1); dbus.schedule = rnd_sched();
      @(posedge clk); #1;
      chk("stall_idx", 64'(cycle_idx_o), 64'd3);
      chk("stall_ctrl", 64'(ctrl_o), 64'(SIX.instruction_controls[3]));
      chk("stall_boundary", 64'(boundary_o), 64'd0);
    end
    irq_take = 1'b0;
    rst_n = 1'b0; mcycle_en = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1; mcycle_en = 1'b0;
    chk("midrst_ctrl", 64'(ctrl_o), 64'(FETCH_CTRL));
    chk("midrst_idx", 64'(cycle_idx_o), 64'd0);

    // six-cycle and zero-cycle schedules
    step(SIX);
    for (int i = 1; i < 6; i++) begin
      step(FETCH_SCHEDULE);
      chk("six_idx", 64'(cycle_idx_o), 64'(i));
    end
    chk("six_boundary", 64'(boundary_o), 64'd1);
    step(FETCH_SCHEDULE);
    chk("six_reload", 64'(ctrl_o), 64'(FETCH_CTRL));
    step(ZERO);
    chk("zero_boundary", 64'(boundary_o), 64'd1);
    chk("zero_ctrl", 64'(ctrl_o), 64'(ZERO.instruction_controls[0]));
    step(FETCH_SCHEDULE);
    chk("zero_reload", 64'(ctrl_o), 64'(FETCH_CTRL));

    // randomized traffic, checked by the model
    for (int i = 0; i < 3000; i++) begin
      rst_n     = ($urandom_range(0, 199) != 0);
      mcycle_en = $urandom_range(0, 1);
      flag_z    = $urandom_range(0, 1);
      flag_c    = $urandom_range(0, 1);
      irq_take  = ($urandom_range(0, 3) == 0);
      #1;
      if (dbus.irq_select) dbus.schedule = DISP;
      else case ($urandom_range(0, 5))
        0: dbus.schedule = FETCH_SCHEDULE;
        1: dbus.schedule = JR;
        2: dbus.schedule = CBP;
        default: dbus.schedule = rnd_sched();
      endcase
      @(posedge clk); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gb_cpu_sequencer.md
GB_CPU_SEQUENCER -- requirements
Module: gb_cpu_sequencer

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, synchronous active-low reset, sampled on clk rising edge.
REQ-003 SHALL have port mcycle_en, input, 1, one-clk strobe marking an M-cycle boundary; state advances only when high.
REQ-004 SHALL have port schedule_i, input, schedule_t, decoder output for the current IR (or IRQ schedule), sampled only at the boundary edge.
REQ-005 SHALL have port flag_z, input, 1, Z bit of F, for condition checks.
REQ-006 SHALL have port flag_c, input, 1, C bit of F, for condition checks.
REQ-007 SHALL have port irq_take, input, 1, interrupt requested and enabled (IME & IE & IF nonzero).
REQ-008 SHALL have port ctrl_o, output, control_signals_t, control word for the current M-cycle.
REQ-009 SHALL have port cycle_idx_o, output, 3, index of the current schedule entry.
REQ-010 SHALL have port cb_mode_o, output, 1, decoder selects CB-prefixed table.
REQ-011 SHALL have port bit_cmd_o, output, 1, latched bit_cmd of the running instruction.
REQ-012 SHALL have port irq_select_o, output, 1, combinational: decoder shall drive the interrupt dispatch schedule on schedule_i.
REQ-013 SHALL have port irq_active_o, output, 1, high for every M-cycle of an interrupt dispatch.
REQ-014 SHALL have port boundary_o, output, 1, combinational: current M-cycle is the last of the instruction.

Function
REQ-015 SHALL hold registers sched_q (schedule_t), idx_q (3 bit), cb_q, irq_q; ctrl_o = sched_q.instruction_controls[idx_q], with no combinational path from any input.
REQ-016 SHALL define last = (m_cycles==0 ? 0 : m_cycles-1), saturated at 5; boundary_o = (idx_q == last) or cc_fail.
REQ-017 SHALL compute cc_fail = ctrl_o.cc_check & !cond_true, where NZ=!flag_z, Z=flag_z, NC=!flag_c, C=flag_c, using sched_q.condition.
REQ-018 SHALL, on mcycle_en & !boundary_o, increment idx_q by 1.
REQ-019 SHALL, on mcycle_en & cc_fail with idx_q < last, set idx_q to last (skip to the fetch entry), not reload.
REQ-020 SHALL, on mcycle_en & (idx_q==last), load sched_q <= schedule_i and idx_q <= 0, so the new entry 0 appears on ctrl_o the cycle after the edge.
REQ-021 SHALL, at a reload, set cb_q <= sched_q.cb_prefix_next (old value) and irq_q <= irq_select_o.
REQ-022 SHALL drive irq_select_o = (idx_q==last) & irq_take & !sched_q.cb_prefix_next & !irq_q; it shall not fire between CB prefix and its opcode or back-to-back dispatches.
REQ-023 SHALL drive cb_mode_o = sched_q.cb_prefix_next & (idx_q==last), so the decoder uses the CB table for the opcode fetched that cycle; the CB instruction itself runs with cb_q=1.
REQ-024 SHALL drive bit_cmd_o = sched_q.bit_cmd and irq_active_o = irq_q.
REQ-025 SHALL hold all registers unchanged when mcycle_en is low, regardless of other inputs.
REQ-026 SHALL treat cc_check on the last entry as a no-op (the reload proceeds normally).

Reset
REQ-027 SHALL, while rst_n=0 at a clk edge, load sched_q <= FETCH_SCHEDULE, idx_q <= 0, cb_q <= 0, irq_q <= 0, overriding mcycle_en.
REQ-028 SHALL therefore show after reset ctrl_o = FETCH_CTRL, cycle_idx_o=0, boundary_o=1, cb_mode_o=0, irq_select_o=0 (while irq_take=0), irq_active_o=0, bit_cmd_o=0.

Structure
REQ-029 SHALL place FETCH_CTRL (addr REG16 PC, receive_data_bus into REG_IR, IDU_INC PC->PC with idu_wren, all else zero/NOP) and FETCH_SCHEDULE (m_cycles=1, entry 0 = FETCH_CTRL, other fields zero) in gb_cpu_common_pkg.
REQ-030 SHALL place a cond_check function (condition_code_t, z, c -> logic) in gb_cpu_common_pkg; no sub-module is required.

Verification
REQ-031 SHALL cover: reset, then 3 strobes with schedule_i = FETCH_SCHEDULE -> ctrl_o stays FETCH_CTRL, idx stays 0.
REQ-032 SHALL cover: 3-cycle schedule (JR NZ), cc_check on entry 0, flag_z=1 -> idx 0 then 2 then reload (2 M-cycles); with flag_z=0 -> idx 0,1,2 (3 M-cycles).
REQ-033 SHALL cover: schedule with cb_prefix_next=1 -> cb_mode_o=1 on its last cycle, next instruction runs with cb_q=1, then cb_mode_o returns to 0.
REQ-034 SHALL cover: irq_take=1 during a CB prefix last cycle -> irq_select_o=0; after the CB op completes -> irq_select_o=1, and irq_active_o=1 for exactly the dispatch schedule's 5 M-cycles.
REQ-035 SHALL cover: mcycle_en low for 10 clks mid-instruction with toggling flags/irq_take -> outputs unchanged; rst_n low at idx 3 -> next cycle FETCH_CTRL, idx 0.
REQ-036 SHALL cover: m_cycles=0 -> treated as 1-cycle instruction; m_cycles=6 -> idx 0..5 then reload.
